// File: rtl/core_pkg.sv
// Shared types and defaults for the core's pipeline control logic.
package core_pkg;

  typedef logic [4:0] reg_t;

  typedef enum logic {
    RUN,
    MDU_WAIT
  } hcu_state_t;

  localparam int MDU_MAX_CYC_DEFAULT = 64;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; async clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, holding once the maximum value is reached
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: load-use stalls, MDU and data-memory wait states,
// and wrong-path flushing on taken branches.
module hazard_control_unit
  import core_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MDU_MAX_CYC = MDU_MAX_CYC_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  reg_t             i_ID_rnum1,
  input  reg_t             i_ID_rnum2,
  input  logic             i_ID_use_rs1,
  input  logic             i_ID_use_rs2,
  input  reg_t             i_EX_wnum,
  input  logic             i_EX_wen,
  input  logic             i_EX_memRead,
  input  logic             i_EX_mdu_op,
  input  logic             i_EX_branch_taken,
  input  logic             i_mdu_done,
  input  logic             i_MEM_memAccess,
  input  logic             i_dmem_ready,
  output logic             o_PC_en,
  output logic             o_pc_redirect,
  output logic             o_IFID_en,
  output logic             o_IDEX_en,
  output logic             o_EXMEM_en,
  output logic             o_MEMWB_en,
  output logic             o_IFID_flush,
  output logic             o_IDEX_flush,
  output logic             o_EXMEM_flush,
  output logic             o_MEMWB_flush,
  output logic             o_mdu_go,
  output logic             o_mdu_timeout,
  output logic [CNT_W-1:0] o_stall_cycles
);

  localparam int MW = $clog2(MDU_MAX_CYC + 1);

  hcu_state_t    state, next_state;
  logic          done_pend, done_pend_nxt;
  logic [MW-1:0] mdu_cnt;
  logic          memwait, loaduse, mdu_finished;

  assign memwait = i_MEM_memAccess & ~i_dmem_ready;
  assign loaduse = i_EX_memRead & i_EX_wen & (i_EX_wnum != '0) &
                   (((i_EX_wnum == i_ID_rnum1) & i_ID_use_rs1) |
                    ((i_EX_wnum == i_ID_rnum2) & i_ID_use_rs2));
  assign mdu_finished = i_mdu_done | done_pend;

  // Priority resolution of stalls, bubbles and redirects for this cycle
  always_comb begin
    o_PC_en       = 1'b1;
    o_pc_redirect = 1'b0;
    o_IFID_en     = 1'b1;
    o_IDEX_en     = 1'b1;
    o_EXMEM_en    = 1'b1;
    o_MEMWB_en    = 1'b1;
    o_IFID_flush  = 1'b0;
    o_IDEX_flush  = 1'b0;
    o_EXMEM_flush = 1'b0;
    o_MEMWB_flush = 1'b0;
    o_mdu_go      = 1'b0;
    next_state    = state;
    done_pend_nxt = done_pend;

    if (memwait) begin
      o_PC_en       = 1'b0;
      o_IFID_en     = 1'b0;
      o_IDEX_en     = 1'b0;
      o_EXMEM_en    = 1'b0;
      o_MEMWB_flush = 1'b1;
      if ((state == MDU_WAIT) && i_mdu_done) begin
        done_pend_nxt = 1'b1;
      end
    end else if ((state == MDU_WAIT) && !mdu_finished) begin
      o_PC_en       = 1'b0;
      o_IFID_en     = 1'b0;
      o_IDEX_en     = 1'b0;
      o_EXMEM_flush = 1'b1;
    end else if (state == MDU_WAIT) begin
      done_pend_nxt = 1'b0;
      next_state    = RUN;
      if (i_EX_branch_taken) begin
        o_pc_redirect = 1'b1;
        o_IFID_flush  = 1'b1;
        o_IDEX_flush  = 1'b1;
      end
    end else if (i_EX_mdu_op) begin
      o_mdu_go      = 1'b1;
      o_PC_en       = 1'b0;
      o_IFID_en     = 1'b0;
      o_IDEX_en     = 1'b0;
      o_EXMEM_flush = 1'b1;
      next_state    = MDU_WAIT;
    end else if (i_EX_branch_taken) begin
      o_pc_redirect = 1'b1;
      o_IFID_flush  = 1'b1;
      o_IDEX_flush  = 1'b1;
    end else if (loaduse) begin
      o_PC_en      = 1'b0;
      o_IFID_en    = 1'b0;
      o_IDEX_flush = 1'b1;
    end
  end

  // FSM state and the remembered early MDU completion
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= RUN;
      done_pend <= 1'b0;
    end else begin
      state     <= next_state;
      done_pend <= done_pend_nxt;
    end
  end

  // MDU wait-length counter, restarted on each new MDU operation
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mdu_cnt <= '0;
    end else if ((state == RUN) && (next_state == MDU_WAIT)) begin
      mdu_cnt <= '0;
    end else if ((state == MDU_WAIT) && (int'(mdu_cnt) < MDU_MAX_CYC)) begin
      mdu_cnt <= mdu_cnt + 1'b1;
    end
  end

  // Sticky timeout flag, raised as the wait counter reaches its limit
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mdu_timeout <= 1'b0;
    end else if ((state == MDU_WAIT) && (int'(mdu_cnt) + 1 >= MDU_MAX_CYC)) begin
      o_mdu_timeout <= 1'b1;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (i_clk),
    .clr  (i_rst),
    .en   (~o_PC_en),
    .count(o_stall_cycles)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_hazard_control_unit;
  import core_pkg::*;

  localparam int CNT_W = 4;
  localparam int MAXC  = 8;
  localparam int SAT   = (1 << CNT_W) - 1;

  typedef struct {
    logic rst;
    reg_t rnum1, rnum2, wnum;
    logic use1, use2, wen, memRead, mduOp, branch, mduDone, memAccess, ready;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  reg_t rnum1, rnum2, wnum;
  logic use1, use2, wen, memRead, mduOp, branch, mduDone, memAccess, ready;
  logic pcEn, redirect, ifidEn, idexEn, exmemEn, memwbEn;
  logic ifidFl, idexFl, exmemFl, memwbFl, mduGo, mduTimeout;
  logic [CNT_W-1:0] stallCycles;

  int vectors = 0;
  int miscompares = 0;

  bit mInMdu, mPend, mTmo;
  int mWait, mStalls;

  always #5 clk = ~clk;

  hazard_control_unit #(
    .CNT_W(CNT_W),
    .MDU_MAX_CYC(MAXC)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ID_rnum1(rnum1), .i_ID_rnum2(rnum2),
    .i_ID_use_rs1(use1), .i_ID_use_rs2(use2),
    .i_EX_wnum(wnum), .i_EX_wen(wen), .i_EX_memRead(memRead),
    .i_EX_mdu_op(mduOp), .i_EX_branch_taken(branch),
    .i_mdu_done(mduDone), .i_MEM_memAccess(memAccess), .i_dmem_ready(ready),
    .o_PC_en(pcEn), .o_pc_redirect(redirect),
    .o_IFID_en(ifidEn), .o_IDEX_en(idexEn), .o_EXMEM_en(exmemEn), .o_MEMWB_en(memwbEn),
    .o_IFID_flush(ifidFl), .o_IDEX_flush(idexFl), .o_EXMEM_flush(exmemFl), .o_MEMWB_flush(memwbFl),
    .o_mdu_go(mduGo), .o_mdu_timeout(mduTimeout), .o_stall_cycles(stallCycles)
  );

  // Bit order: PC_en, redirect, IFID/IDEX/EXMEM/MEMWB en, same four flushes, go
  function automatic logic [10:0] dutVec();
    return {pcEn, redirect, ifidEn, idexEn, exmemEn, memwbEn,
            ifidFl, idexFl, exmemFl, memwbFl, mduGo};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.rnum1 = '0; s.rnum2 = '0; s.wnum = '0;
    s.use1 = 1'b0; s.use2 = 1'b0; s.wen = 1'b0; s.memRead = 1'b0;
    s.mduOp = 1'b0; s.branch = 1'b0; s.mduDone = 1'b0;
    s.memAccess = 1'b0; s.ready = 1'b0;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    rst = s.rst; rnum1 = s.rnum1; rnum2 = s.rnum2; wnum = s.wnum;
    use1 = s.use1; use2 = s.use2; wen = s.wen; memRead = s.memRead;
    mduOp = s.mduOp; branch = s.branch; mduDone = s.mduDone;
    memAccess = s.memAccess; ready = s.ready;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: predict this cycle's outputs from the rules, compare, then advance
  always @(negedge clk) begin : model
    bit mw, lu, pc, rd, e1, e2, e3, e4, f1, f2, f3, f4, go;
    logic [10:0] expv;
    if (rst === 1'b1) begin
      mInMdu = 0; mPend = 0; mTmo = 0; mWait = 0; mStalls = 0;
    end
    mw = memAccess & ~ready;
    lu = memRead & wen & (wnum != 0) &
         ((wnum == rnum1 & use1) | (wnum == rnum2 & use2));
    pc = 1; rd = 0; e1 = 1; e2 = 1; e3 = 1; e4 = 1;
    f1 = 0; f2 = 0; f3 = 0; f4 = 0; go = 0;
    if (mw) begin
      pc = 0; e1 = 0; e2 = 0; e3 = 0; f4 = 1;
    end else if (mInMdu && !(mduDone || mPend)) begin
      pc = 0; e1 = 0; e2 = 0; f3 = 1;
    end else if (mInMdu) begin
      if (branch) begin rd = 1; f1 = 1; f2 = 1; end
    end else if (mduOp) begin
      go = 1; pc = 0; e1 = 0; e2 = 0; f3 = 1;
    end else if (branch) begin
      rd = 1; f1 = 1; f2 = 1;
    end else if (lu) begin
      pc = 0; e1 = 0; f2 = 1;
    end
    expv = {pc, rd, e1, e2, e3, e4, f1, f2, f3, f4, go};
    checkOutput("ctrl_vector", 32'(dutVec()), 32'(expv));
    checkOutput("stall_cycles", 32'(stallCycles), 32'(mStalls));
    checkOutput("mdu_timeout", 32'(mduTimeout), 32'(mTmo));
    if (rst !== 1'b1) begin
      if (!pc && mStalls < SAT) mStalls++;
      if (mInMdu) begin
        mWait++;
        if (mWait >= MAXC) mTmo = 1;
      end
      if (mw) begin
        if (mInMdu && mduDone) mPend = 1;
      end else if (mInMdu) begin
        if (mduDone || mPend) begin mInMdu = 0; mPend = 0; end
      end else if (mduOp) begin
        mInMdu = 1; mWait = 0;
      end
    end
  end

  // Directed scenarios with literal expectations, then random traffic
  initial begin
    stim_t s;
    s = idle(); s.rst = 1'b1;
    applyStimulus(s);
    nextCycle(); nextCycle();
    s = idle(); applyStimulus(s); #2;
    checkOutput("reset_vec", 32'(dutVec()), 32'(11'b1_0_1111_0000_0));
    checkOutput("reset_stall", 32'(stallCycles), 0);
    checkOutput("reset_tmo", 32'(mduTimeout), 0);
    nextCycle();

    s = idle(); s.memRead = 1; s.wen = 1; s.wnum = 5; s.rnum1 = 5; s.use1 = 1;
    applyStimulus(s); #2;
    checkOutput("loaduse_vec", 32'(dutVec()), 32'(11'b0_0_0111_0100_0));
    nextCycle();
    s = idle(); applyStimulus(s); #2;
    checkOutput("after_loaduse_vec", 32'(dutVec()), 32'(11'b1_0_1111_0000_0));
    checkOutput("after_loaduse_stall", 32'(stallCycles), 1);
    nextCycle();

    s = idle(); s.memRead = 1; s.wen = 1; s.wnum = 0; s.rnum1 = 0; s.use1 = 1;
    applyStimulus(s); #2;
    checkOutput("load_x0_vec", 32'(dutVec()), 32'(11'b1_0_1111_0000_0));
    nextCycle();

    s = idle(); s.memRead = 1; s.wen = 1; s.wnum = 7; s.rnum2 = 7; s.use2 = 1; s.branch = 1;
    applyStimulus(s); #2;
    checkOutput("branch_loaduse_vec", 32'(dutVec()), 32'(11'b1_1_1111_1100_0));
    nextCycle();

    for (int c = 0; c <= 6; c++) begin
      s = idle(); s.mduOp = (c <= 5); s.mduDone = (c == 5);
      applyStimulus(s); #2;
      if (c == 0) checkOutput("mdu_go_vec", 32'(dutVec()), 32'(11'b0_0_0011_0010_1));
      else if (c <= 4) checkOutput("mdu_wait_vec", 32'(dutVec()), 32'(11'b0_0_0011_0010_0));
      else checkOutput("mdu_done_vec", 32'(dutVec()), 32'(11'b1_0_1111_0000_0));
      if (c == 6) checkOutput("mdu_stall", 32'(stallCycles), 6);
      nextCycle();
    end

    for (int c = 0; c <= 6; c++) begin
      s = idle(); s.mduOp = (c <= 5);
      s.memAccess = (c >= 2 && c <= 5); s.ready = (c == 5); s.mduDone = (c == 3);
      applyStimulus(s); #2;
      if (c >= 2 && c <= 4) checkOutput("memwait_vec", 32'(dutVec()), 32'(11'b0_0_0001_0001_0));
      if (c >= 5) checkOutput("memwait_release_vec", 32'(dutVec()), 32'(11'b1_0_1111_0000_0));
      if (c == 6) checkOutput("memwait_stall", 32'(stallCycles), 11);
      nextCycle();
    end

    for (int c = 0; c <= 10; c++) begin
      s = idle(); s.mduOp = 1;
      applyStimulus(s); #2;
      if (c == 8) checkOutput("tmo_before", 32'(mduTimeout), 0);
      if (c >= 9) checkOutput("tmo_after", 32'(mduTimeout), 1);
      if (c == 9) checkOutput("stall_saturated", 32'(stallCycles), SAT);
      nextCycle();
    end

    s = idle(); s.rst = 1;
    applyStimulus(s); #2;
    checkOutput("midmdu_reset_vec", 32'(dutVec()), 32'(11'b1_0_1111_0000_0));
    checkOutput("midmdu_reset_tmo", 32'(mduTimeout), 0);
    checkOutput("midmdu_reset_stall", 32'(stallCycles), 0);
    nextCycle();
    s = idle(); applyStimulus(s); #2;
    checkOutput("post_reset_run_vec", 32'(dutVec()), 32'(11'b1_0_1111_0000_0));
    nextCycle();

    for (int n = 0; n < 3000; n++) begin
      s.rst       = ($urandom_range(0, 199) == 0);
      s.rnum1     = reg_t'($urandom_range(0, 3));
      s.rnum2     = reg_t'($urandom_range(0, 3));
      s.wnum      = reg_t'($urandom_range(0, 3));
      s.use1      = $urandom_range(0, 1) == 1;
      s.use2      = $urandom_range(0, 1) == 1;
      s.wen       = $urandom_range(0, 3) != 0;
      s.memRead   = $urandom_range(0, 9) < 3;
      s.mduOp     = $urandom_range(0, 9) == 0;
      s.branch    = $urandom_range(0, 19) < 3;
      s.mduDone   = $urandom_range(0, 19) < 3;
      s.memAccess = $urandom_range(0, 9) < 3;
      s.ready     = $urandom_range(0, 1) == 1;
      applyStimulus(s);
      nextCycle();
    end

    s = idle(); applyStimulus(s);
    nextCycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
